// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BTB branch predictor: combinational lookup at fetch,
// trained from the execute stage with resolved branch/jump outcomes.
module riscv_branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            inv_all
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  // Instruction-alignment bits carry no prediction information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{f_pc[1:0], upd_pc[1:0]};

  // Lookup: reads only registered state, so it returns pre-update contents.
  logic [IDX-1:0]  f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;

  assign f_idx       = f_pc[IDX+1:2];
  assign f_tag       = f_pc[XLEN-1:IDX+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
  assign pred_target = pred_taken ? target_q[f_idx] : f_pc + XLEN'(4);

  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;
  logic            u_hit;
  logic            do_jump;
  logic            do_branch;
  logic            alloc;
  logic            train;
  logic            wr_target;
  logic [1:0]      ctr_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    u_idx     = upd_pc[IDX+1:2];
    u_tag     = upd_pc[XLEN-1:IDX+2];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // Jumps win over the branch flag; reset and invalidate discard the update.
    do_jump   = upd_valid && upd_is_jump && !inv_all && !reset;
    do_branch = upd_valid && upd_is_branch && !upd_is_jump && !inv_all && !reset;
    alloc     = do_jump || (do_branch && !u_hit && upd_taken);
    train     = do_branch && u_hit;
    wr_target = alloc || (train && upd_taken);
    ctr_next  = ctr_q[u_idx];
    if (do_jump) begin
      ctr_next = 2'b11;
    end else if (alloc) begin
      ctr_next = 2'b10;
    end else if (upd_taken) begin
      if (ctr_q[u_idx] != 2'b11) ctr_next = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) ctr_next = ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= ctr_next;
    end else if (train) begin
      ctr_q[u_idx]   <= ctr_next;
    end
  end

  // NOTE: tag/target/jump storage is deliberately not reset; valid=0 masks it,
  // which lets these arrays map onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[u_idx]  <= u_tag;
      jump_q[u_idx] <= do_jump;
    end
    if (wr_target) begin
      target_q[u_idx] <= upd_target;
    end
  end

endmodule
